// File: rtl/lcd_pkg.sv
// Shared HD44780-style bus definitions used by the LCD writer and responder.
package lcd_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AC_W   = 7;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CELLS  = 32;

  // Instruction opcode masks; the highest set bit selects the instruction.
  localparam logic [7:0] OP_CLR     = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPCTL = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [7:0] BLANK      = 8'h20;

  // One bus transfer as captured on the last en-high cycle.
  typedef struct packed {
    logic              rs;
    logic              rw;
    logic [DATA_W-1:0] data;
  } lcd_xfer_t;

  // Step the address counter across the two 16-column lines, wrapping line to line.
  function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac, input logic inc);
    logic [AC_W-1:0] r;
    if (inc) begin
      if (ac[3:0] == 4'hF) r = ac[6] ? LINE0_BASE : LINE1_BASE;
      else                 r = {ac[6], 2'b00, 4'(ac[3:0] + 4'd1)};
    end else begin
      if (ac[3:0] == 4'h0) r = ac[6] ? (LINE0_BASE | 7'h0F) : (LINE1_BASE | 7'h0F);
      else                 r = {ac[6], 2'b00, 4'(ac[3:0] - 4'd1)};
    end
    return r;
  endfunction

  // DDRAM cell index {line, col} for an address counter value.
  function automatic logic [IDX_W-1:0] ac_idx(input logic [AC_W-1:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Synchronizes the asynchronous LCD bus and turns valid en pulses into strobes.
module lcd_strobe_sync
  import lcd_pkg::*;
#(
  parameter int unsigned MIN_EN_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_rs,
  input  logic              lcd_rw,
  input  logic              lcd_en,
  input  logic [DATA_W-1:0] lcd_data,
  output logic              en_sync,
  output logic              rs_sync,
  output logic              rw_sync,
  output logic              stb,
  output logic              short_pulse,
  output lcd_xfer_t         xfer
);

  localparam int unsigned SYNC_W = DATA_W + 3;
  localparam int unsigned CNT_W  = $clog2(MIN_EN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_EN_CYC);

  logic [SYNC_W-1:0] meta_q;
  logic [SYNC_W-1:0] sync_q;
  logic              en_q;
  logic [CNT_W-1:0]  hi_cnt;
  lcd_xfer_t         cap_q;

  assign en_sync = sync_q[SYNC_W-1];
  assign rs_sync = sync_q[SYNC_W-2];
  assign rw_sync = sync_q[SYNC_W-3];
  assign xfer    = cap_q;

  // Two-flop synchronizer for every bus line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
      sync_q <= meta_q;
    end
  end

  // Count en-high cycles, capture the bus while en is high, and qualify the falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q        <= 1'b0;
      hi_cnt      <= '0;
      cap_q       <= '0;
      stb         <= 1'b0;
      short_pulse <= 1'b0;
    end else begin
      en_q        <= en_sync;
      stb         <= 1'b0;
      short_pulse <= 1'b0;
      if (en_sync) begin
        cap_q <= lcd_xfer_t'(sync_q[SYNC_W-2:0]);
        if (!en_q)                 hi_cnt <= CNT_W'(1);
        else if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_W'(1);
      end else if (en_q) begin
        if (hi_cnt >= CNT_MAX) stb         <= 1'b1;
        else                   short_pulse <= 1'b1;
        hi_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// Responder side of the character-LCD bus: DDRAM image, address counter, flags and busy timer.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CLR_CYC = 82080,
  parameter int unsigned BUSY_CMD_CYC = 2160,
  parameter int unsigned MIN_EN_CYC   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_rs,
  input  logic              lcd_rw,
  input  logic              lcd_en,
  input  logic [DATA_W-1:0] lcd_data,
  output logic [DATA_W-1:0] lcd_dout,
  output logic              lcd_doe,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_char,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              disp_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic              busy,
  output logic              cmd_stb,
  output logic              err
);

  localparam int unsigned BUSY_MAX = (BUSY_CLR_CYC > BUSY_CMD_CYC) ? BUSY_CLR_CYC : BUSY_CMD_CYC;
  localparam int unsigned BCNT_W   = $clog2(BUSY_MAX + 1);

  logic              en_sync, rs_sync, rw_sync;
  logic              stb, short_pulse;
  lcd_xfer_t         xfer;

  logic [AC_W-1:0]   ac;
  logic              id;
  logic [DATA_W-1:0] ddram [CELLS];
  logic [BCNT_W-1:0] busy_cnt;
  logic              sweep_on;
  logic [IDX_W-1:0]  sweep_idx;

  logic [AC_W-1:0]   ac_nxt;
  logic              id_nxt, disp_nxt, cursor_nxt, blink_nxt;
  logic              accept, err_set, load_busy, long_busy, sweep_go, mem_we;
  logic [DATA_W-1:0] d;

  assign cur_idx = ac_idx(ac);

  lcd_strobe_sync #(
    .MIN_EN_CYC(MIN_EN_CYC)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data),
    .en_sync    (en_sync),
    .rs_sync    (rs_sync),
    .rw_sync    (rw_sync),
    .stb        (stb),
    .short_pulse(short_pulse),
    .xfer       (xfer)
  );

  // Decode a strobe into next register state, busy load and error reporting.
  always_comb begin
    ac_nxt     = ac;
    id_nxt     = id;
    disp_nxt   = disp_on;
    cursor_nxt = cursor_on;
    blink_nxt  = blink_on;
    accept     = 1'b0;
    err_set    = short_pulse;
    load_busy  = 1'b0;
    long_busy  = 1'b0;
    sweep_go   = 1'b0;
    mem_we     = 1'b0;
    d          = xfer.data;
    if (stb) begin
      if (!xfer.rw) begin
        if (busy) begin
          err_set = 1'b1;
        end else begin
          accept    = 1'b1;
          load_busy = 1'b1;
          if (xfer.rs) begin
            mem_we = 1'b1;
            ac_nxt = ac_step(ac, id);
          end else if ((d & OP_DDRAM) != '0) begin
            ac_nxt = {d[6], 2'b00, d[3:0]};
            if (d[5:4] != 2'b00) err_set = 1'b1;
          end else if ((d & OP_CGRAM) != '0) begin
            err_set = 1'b1;
          end else if ((d & OP_FUNC) != '0) begin
            if (!d[4]) err_set = 1'b1;
          end else if ((d & OP_SHIFT) != '0) begin
            if (d[3]) err_set = 1'b1;
            else      ac_nxt  = ac_step(ac, d[2]);
          end else if ((d & OP_DISPCTL) != '0) begin
            {disp_nxt, cursor_nxt, blink_nxt} = d[2:0];
          end else if ((d & OP_ENTRY) != '0) begin
            id_nxt = d[1];
            if (d[0]) err_set = 1'b1;
          end else if ((d & OP_HOME) != '0) begin
            ac_nxt    = '0;
            long_busy = 1'b1;
          end else if ((d & OP_CLR) != '0) begin
            ac_nxt    = '0;
            id_nxt    = 1'b1;
            long_busy = 1'b1;
            sweep_go  = 1'b1;
          end
        end
      end else begin
        accept = 1'b1;
        if (xfer.rs) begin
          if (busy) err_set = 1'b1;
          else      ac_nxt  = ac_step(ac, id);
        end
      end
    end
  end

  // Control registers, strobe acknowledge and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ac        <= '0;
      id        <= 1'b1;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      cmd_stb   <= 1'b0;
      err       <= 1'b0;
    end else begin
      ac        <= ac_nxt;
      id        <= id_nxt;
      disp_on   <= disp_nxt;
      cursor_on <= cursor_nxt;
      blink_on  <= blink_nxt;
      cmd_stb   <= accept;
      if (err_set) err <= 1'b1;
    end
  end

  // Busy timer: high for exactly the loaded number of cycles starting with cmd_stb.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      busy_cnt <= '0;
    end else if (load_busy) begin
      busy     <= 1'b1;
      busy_cnt <= long_busy ? BCNT_W'(BUSY_CLR_CYC) : BCNT_W'(BUSY_CMD_CYC);
    end else if (busy) begin
      if (busy_cnt <= BCNT_W'(1)) begin
        busy     <= 1'b0;
        busy_cnt <= '0;
      end else begin
        busy_cnt <= busy_cnt - BCNT_W'(1);
      end
    end
  end

  // DDRAM image: data writes and the 32-cycle blanking sweep after clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CELLS; i++) ddram[i] <= BLANK;
      sweep_on  <= 1'b0;
      sweep_idx <= '0;
    end else begin
      if (sweep_go) begin
        sweep_on  <= 1'b1;
        sweep_idx <= '0;
      end else if (sweep_on) begin
        ddram[sweep_idx] <= BLANK;
        sweep_idx        <= sweep_idx + IDX_W'(1);
        if (sweep_idx == IDX_W'(CELLS - 1)) sweep_on <= 1'b0;
      end
      if (mem_we) ddram[cur_idx] <= xfer.data;
    end
  end

  // Read ports: bus read-back while en and rw are high, plus the mirror port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lcd_doe  <= 1'b0;
      lcd_dout <= '0;
      rd_char  <= '0;
    end else begin
      lcd_doe  <= en_sync & rw_sync;
      if (en_sync & rw_sync) lcd_dout <= rs_sync ? ddram[cur_idx] : {busy, ac};
      else                   lcd_dout <= '0;
      rd_char  <= ddram[rd_idx];
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized self-checking bench for lcd_bus_responder against a linear-position display model.
module tb_lcd_bus_responder;
  import lcd_pkg::*;

  localparam int CLR  = 400;
  localparam int CMD  = 60;
  localparam int MINC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [7:0] lcd_dout;
  logic       lcd_doe;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] rd_char;
  logic [4:0] cur_idx;
  logic       disp_on, cursor_on, blink_on, busy, cmd_stb, err;

  always #5 clk = ~clk;

  lcd_bus_responder #(
    .BUSY_CLR_CYC(CLR),
    .BUSY_CMD_CYC(CMD),
    .MIN_EN_CYC  (MINC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data),
    .lcd_dout (lcd_dout),
    .lcd_doe  (lcd_doe),
    .rd_idx   (rd_idx),
    .rd_char  (rd_char),
    .cur_idx  (cur_idx),
    .disp_on  (disp_on),
    .cursor_on(cursor_on),
    .blink_on (blink_on),
    .busy     (busy),
    .cmd_stb  (cmd_stb),
    .err      (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor: cycle counter, strobe count and busy edges.
  int   cyc = 0, rise_cyc = 0, fall_cyc = 0, stb_count = 0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (cmd_stb) stb_count++;
    if (!busy_q && busy) rise_cyc = cyc;
    if (busy_q && !busy) fall_cyc = cyc;
    busy_q = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: cursor as a linear position 0..31 over the two lines.
  logic [7:0] m_mem [32];
  int         m_pos;
  bit         m_id, m_d, m_c, m_b, m_err;

  function automatic logic [6:0] m_ac();
    return 7'((m_pos / 16) * 64 + (m_pos % 16));
  endfunction

  function automatic void m_step(input bit inc);
    m_pos = inc ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_pos = 0; m_id = 1; m_d = 0; m_c = 0; m_b = 0; m_err = 0;
  endfunction

  // Apply an accepted write; returns the busy time it causes.
  function automatic int m_write(input bit rs, input logic [7:0] d);
    int a;
    if (rs) begin
      m_mem[m_pos] = d;
      m_step(m_id);
      return CMD;
    end
    if (d >= 8'h80) begin
      a = int'(d) - 128;
      if (!(a < 16 || (a >= 64 && a < 80))) m_err = 1;
      m_pos = (a >= 64 ? 16 : 0) + a % 16;
    end else if (d >= 8'h40) m_err = 1;
    else if (d >= 8'h20) begin
      if (d < 8'h30) m_err = 1;
    end else if (d >= 8'h10) begin
      if (d >= 8'h18) m_err = 1;
      else            m_step(d[2]);
    end else if (d >= 8'h08) begin
      m_d = d[2]; m_c = d[1]; m_b = d[0];
    end else if (d >= 8'h04) begin
      m_id = d[1];
      if (d[0]) m_err = 1;
    end else if (d >= 8'h02) begin
      m_pos = 0;
      return CLR;
    end else if (d == 8'h01) begin
      m_pos = 0; m_id = 1;
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      return CLR;
    end
    return CMD;
  endfunction

  // Drive one en pulse of hi cycles; samples the read bus on the last high cycle.
  task automatic lcd_op(input bit rs, input bit rw, input logic [7:0] d, input int hi,
                        output logic [7:0] dout_s, output logic doe_s);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (hi - 1) @(negedge clk);
    dout_s = lcd_dout;
    doe_s  = lcd_doe;
    @(negedge clk);
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_op(input bit rs, input bit rw, input logic [7:0] d, input int hi,
                       input bit busy_now, output int dur);
    int         stb0;
    logic [7:0] ds, exp_dout;
    logic       es;
    bit         acc;
    dur = 0; stb0 = stb_count; acc = 0; exp_dout = 8'h00;
    if (rw) exp_dout = rs ? m_mem[m_pos] : {busy_now, m_ac()};
    if (hi < MINC) m_err = 1;
    else if (!rw && busy_now) m_err = 1;
    else begin
      acc = 1;
      if (!rw) dur = m_write(rs, d);
      else if (rs) begin
        if (busy_now) m_err = 1;
        else          m_step(m_id);
      end
    end
    lcd_op(rs, rw, d, hi, ds, es);
    check("cmd_stb_count", 32'(stb_count - stb0), acc ? 32'd1 : 32'd0);
    if (rw && hi >= 5) begin
      check("read_doe", 32'(es), 32'd1);
      check("read_dout", 32'(ds), 32'(exp_dout));
    end
  endtask

  task automatic wait_idle(input int dur);
    int n = 0;
    while (busy && n < CLR + 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= CLR + 200) check("busy_timeout", 32'(busy), 32'd0);
    if (dur > 0) check("busy_len", 32'(fall_cyc - rise_cyc), 32'(dur));
  endtask

  task automatic wr(input bit rs, input logic [7:0] d);
    int dur;
    do_op(rs, 1'b0, d, 4, 1'b0, dur);
    wait_idle(dur);
  endtask

  task automatic check_cell(input int i);
    rd_idx = 5'(i);
    @(negedge clk);
    check("ddram", 32'(rd_char), 32'(m_mem[i]));
  endtask

  task automatic check_cells();
    for (int i = 0; i < 32; i++) check_cell(i);
  endtask

  task automatic check_state();
    check("cur_idx", 32'(cur_idx), 32'(m_pos));
    check("flags", 32'({disp_on, cursor_on, blink_on}), 32'({m_d, m_c, m_b}));
    check("err", 32'(err), 32'(m_err));
    check_cell($urandom_range(0, 31));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({err, cmd_stb, lcd_doe, lcd_dout, cur_idx, disp_on, cursor_on, blink_on}), 32'd0);
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_instr();
    int r = $urandom_range(0, 19);
    case (r)
      0:       return 8'($urandom);
      1, 2:    return 8'h80 | ($urandom_range(0, 1) ? 8'h40 : 8'h00) | 8'($urandom_range(0, 15));
      3, 4:    return 8'h30 | (8'($urandom) & 8'h0C);
      5, 6, 7: return 8'h10 | (8'($urandom) & 8'h04);
      8, 9:    return 8'h08 | (8'($urandom) & 8'h07);
      10, 11:  return 8'h04 | (8'($urandom) & 8'h02);
      12:      return 8'h02 | (8'($urandom) & 8'h01);
      13:      return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  task automatic random_phase(input int n);
    int dur, dd, kind;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 99);
      if (kind < 40) begin
        do_op(1'b1, 1'b0, 8'($urandom), $urandom_range(3, 6), 1'b0, dur);
        wait_idle(dur);
      end else if (kind < 70) begin
        do_op(1'b0, 1'b0, rand_instr(), $urandom_range(3, 6), 1'b0, dur);
        wait_idle(dur);
      end else if (kind < 85) begin
        do_op(1'($urandom), 1'b1, 8'($urandom), 6, 1'b0, dd);
      end else if (kind < 88) begin
        do_op(1'b1, 1'b0, 8'($urandom), $urandom_range(1, 2), 1'b0, dd);
      end else begin
        do_op(1'b1, 1'b0, 8'($urandom), 4, 1'b0, dur);
        do_op(1'($urandom), 1'($urandom), 8'($urandom), 6, 1'b1, dd);
        wait_idle(dur);
      end
      check_state();
    end
  endtask

  initial begin
    int dur, dd;
    m_reset();
    apply_reset();
    check_state();

    // Power-up writer sequence, then " Kim".
    wr(0, 8'h38); wr(0, 8'h01); wr(0, 8'h0C); wr(0, 8'h06); wr(0, 8'h80);
    wr(1, 8'h20); wr(1, 8'h4B); wr(1, 8'h69); wr(1, 8'h6D);
    check_cell(1); check_cell(2); check_cell(3);
    check_state();

    // Line wrap in both directions.
    wr(0, 8'h8F); wr(1, 8'h41);
    check("wrap_inc_idx", 32'(cur_idx), 32'd16);
    check_cell(15);
    wr(0, 8'h04); wr(1, 8'h42);
    check("wrap_dec_idx", 32'(cur_idx), 32'd15);
    check_cell(16);

    // Busy-flag read right after a command and again once idle; data read while busy.
    do_op(0, 0, 8'h0C, 4, 0, dur);
    do_op(0, 1, 8'h00, 6, 1, dd);
    do_op(1, 1, 8'h00, 6, 1, dd);
    check("busy_read_err", 32'(err), 32'd1);
    wait_idle(dur);
    do_op(0, 1, 8'h00, 6, 0, dd);
    check_state();

    // Write during clear busy is dropped; full clear length; all cells blank.
    apply_reset();
    wr(1, 8'h55);
    do_op(0, 0, 8'h01, 4, 0, dur);
    repeat (100) @(negedge clk);
    do_op(1, 0, 8'h41, 4, 1, dd);
    check("drop_err", 32'(err), 32'd1);
    wait_idle(dur);
    check_cells();

    // Too-short en pulse is ignored.
    apply_reset();
    do_op(1, 0, 8'h41, 2, 0, dd);
    check("short_err", 32'(err), 32'd1);
    check_state();

    // Illegal DDRAM address.
    apply_reset();
    wr(0, 8'h9F);
    check("bad_addr_err", 32'(err), 32'd1);
    check("bad_addr_idx", 32'(cur_idx), 32'd15);

    // Reset mid-busy after a data write, then mid-clear-sweep.
    apply_reset();
    do_op(1, 0, 8'h4B, 4, 0, dur);
    apply_reset();
    check_cells();
    wr(1, 8'h4B); wr(1, 8'h4C);
    do_op(0, 0, 8'h01, 4, 0, dur);
    repeat (8) @(negedge clk);
    apply_reset();
    check_cells();
    check_state();

    // Randomized traffic, split by a reset so the sticky error is exercised twice.
    random_phase(150);
    apply_reset();
    random_phase(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Responder end of the team's HD44780-style character-LCD bus: samples lcd_rs/lcd_rw/lcd_en/lcd_data driven by an LCD writer and decodes instructions and data.
- Holds a 2x16 DDRAM image, address counter (AC), display flags and a busy timer. Answers busy-flag/data reads.
- Used as an on-chip display model (bench and board-level mirror to VGA/UART via the read port).

Parameters:
- BUSY_CLR_CYC, 82080, busy duration in clk cycles after clear/return-home (1.52 ms at 54 MHz).
- BUSY_CMD_CYC, 2160, busy duration after any other instruction or data write (40 us at 54 MHz).
- MIN_EN_CYC, 3, minimum synchronized en-high cycles for a valid strobe.

Ports:
- clk  in  1  system clock
- reset  in  1  reset reset, asynchronous, active-low; clock clk
- lcd_rs  in  1  register select (0 instruction, 1 data)
- lcd_rw  in  1  0 write, 1 read
- lcd_en  in  1  enable strobe, asynchronous to clk
- lcd_data  in  8  bus data from writer
- lcd_dout  out  8  read-back data
- lcd_doe  out  1  read-back drive enable
- rd_idx  in  5  DDRAM read index {line, col}
- rd_char  out  8  DDRAM[rd_idx], registered, 1-cycle latency
- cur_idx  out  5  {AC[6], AC[3:0]}
- disp_on / cursor_on / blink_on  out  1 each  display-control flags
- busy  out  1  busy flag
- cmd_stb  out  1  one-cycle pulse per accepted strobe
- err  out  1  sticky: unsupported/illegal access; cleared only by reset

Behaviour:
- Sync: rs, rw, en, data each pass through 2 flops. A strobe is the falling edge of synced en after at least MIN_EN_CYC high cycles. Shorter pulses are ignored and set err. rs/rw/data are captured on the last en-high cycle.
- Reset values: DDRAM all 0x20; AC=0; I/D=1; disp_on=cursor_on=blink_on=0; busy=0; err=0; all outputs 0.
- Writes (rw=0) while busy=1 are dropped, set err, and produce no cmd_stb.
- Accepted write: cmd_stb pulses 1 cycle after the strobe. Busy asserts on that same cycle and the counter loads its duration.
- Instruction decode, highest set bit wins:
  - 0x80|a: set AC=a. Legal a is 0x00-0x0F or 0x40-0x4F. Other values set err and store AC={a[6],2'b00,a[3:0]}.
  - 0x40-0x7F: CGRAM address; ignored, err set.
  - 0x20-0x3F: function set. DL=0 sets err (only 8-bit mode supported); N and F are ignored.
  - 0x10-0x1F: S/C=0 moves AC right (R/L=1) or left with the wrap rules below. S/C=1 (display shift) is ignored and sets err.
  - 0x08-0x0F: disp_on=D, cursor_on=C, blink_on=B.
  - 0x04-0x07: I/D stored; S=1 sets err.
  - 0x02/0x03: AC=0; busy for BUSY_CLR_CYC.
  - 0x01: AC=0, I/D=1, then 32-cycle sweep writing 0x20 to idx 0..31; busy for BUSY_CLR_CYC.
  - 0x00: no-op, busy for BUSY_CMD_CYC.
- Data write (rs=1): DDRAM[cur_idx]=data, then AC steps by I/D.
- AC wrap:
  - Increment: 0x0F->0x40, 0x4F->0x00.
  - Decrement: 0x00->0x4F, 0x40->0x0F.
- Reads (rw=1), allowed even while busy:
  - lcd_doe is high while synced en=1 and rw=1; lcd_dout is valid from the 2nd en-high cycle.
  - rs=0 returns {busy, AC[6:0]}.
  - rs=1 returns DDRAM[cur_idx] and AC steps by I/D on the strobe. If busy=1, AC does not step and err is set.
- A new strobe during the clear sweep is impossible because busy blocks writes; reads during the sweep return the sweep-in-progress contents.
- Reset mid-sweep or mid-busy: everything returns immediately to reset values.

Decomposition:
- Shared package lcd_pkg holds the instruction opcode masks (CLR, HOME, ENTRY, DISPCTL, SHIFT, FUNC, CGRAM, DDRAM), the DDRAM line base constants 0x00/0x40, and the 0x20 blank code. The LCD writer uses the same package.
- One natural sub-module: lcd_strobe_sync (2-flop sync, en pulse-width check, capture and strobe generation).

Test Plan:
- Writer sequence 0x38, 0x01, 0x0C, 0x06, 0x80, then data " Kim" at 54 MHz pacing -> rd_char idx1..3 = 'K','i','m'; disp_on=1, cursor_on=0; err=0.
- Data write at AC=0x0F -> stored at idx15, cur_idx=16 (AC=0x40). With I/D=0, data at AC=0x40 -> AC=0x0F.
- 0x01 followed 1000 cycles later by 0x41-byte data write -> write dropped, err=1; busy stays high for 82080 cycles; all 32 cells read 0x20.
- rw=1, rs=0 read right after 0x0C -> lcd_dout[7]=1 and lcd_doe high during en. After 2160 cycles, same read returns 0x00|AC.
- en pulse of 2 clk cycles carrying 0x41 data -> ignored, no cmd_stb, err=1.
- 0x9F (illegal DDRAM address) -> err=1, cur_idx=15. Assert reset mid-clear -> DDRAM all 0x20, busy=0 on the next cycle.
